ctrl_pipeline: RTL
==================

Name: ctrl_pipeline

Overview:
- Consumer end of the decode control bundle (Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite).
- Carries the bundle through ID/EX, EX/MEM and MEM/WB registers and delivers each field to its consuming stage.
- Contains load-use hazard detection (stall and bubble insertion), EX-operand forwarding select, and ID-stage branch flush.
- Sits between the decode control unit and the 5-stage RISC-V datapath.

Parameters:
- REG_ADDR_W, 5, register address width.
- ALUOP_W, 2, ALUOp field width; must match the decode control unit.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- Branch_i  in  1  decode Branch.
- MemRead_i  in  1  decode MemRead.
- MemtoReg_i  in  1  decode MemtoReg.
- ALUOp_i  in  ALUOP_W  decode ALUOp.
- MemWrite_i  in  1  decode MemWrite.
- ALUSrc_i  in  1  decode ALUSrc.
- RegWrite_i  in  1  decode RegWrite.
- RS1addr_i  in  REG_ADDR_W  ID-stage rs1.
- RS2addr_i  in  REG_ADDR_W  ID-stage rs2.
- RDaddr_i  in  REG_ADDR_W  ID-stage rd.
- BranchEq_i  in  1  ID-stage rs1 data equals rs2 data.
- ALUOp_EX_o  out  ALUOP_W  to ALU control.
- ALUSrc_EX_o  out  1  ALU operand-B mux select.
- ForwardA_o  out  2  EX operand-A source.
- ForwardB_o  out  2  EX operand-B source.
- MemRead_MEM_o  out  1  data-memory read enable.
- MemWrite_MEM_o  out  1  data-memory write enable.
- RDaddr_MEM_o  out  REG_ADDR_W  EX/MEM rd.
- RegWrite_WB_o  out  1  register-file write enable.
- MemtoReg_WB_o  out  1  writeback mux select.
- RDaddr_WB_o  out  REG_ADDR_W  register-file write address.
- Stall_o  out  1  hold IF/ID register.
- PCWrite_o  out  1  PC update enable; equals ~Stall_o.
- Flush_o  out  1  clear IF/ID register (taken branch).

Behaviour:
- Reset (rst_i=1 at edge): all stage registers cleared to 0, including every control bit, rd, rs1 and rs2.
- Outputs in the cycle after reset: all 0 except PCWrite_o=1.
- rst_i mid-operation overrides stall, and any in-flight store/regwrite is discarded.
- ID/EX register captures ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, rs1, rs2 and rd.
- EX/MEM register captures RegWrite, MemtoReg, MemRead, MemWrite and rd from ID/EX.
- MEM/WB register captures RegWrite, MemtoReg and rd from EX/MEM.
- Latency from decode input to a stage output: EX-stage outputs 1 cycle, MEM-stage outputs 2 cycles, WB-stage outputs 3 cycles.
- Load-use hazard (combinational): Stall_o=1 iff all of the following hold:
  - ID/EX MemRead=1;
  - ID/EX rd != 0;
  - ID/EX rd equals RS1addr_i, or ID/EX rd equals RS2addr_i.
- The rs2 comparison is applied regardless of the consuming opcode (conservative).
- On Stall_o=1:
  - ID/EX loads a bubble (all controls 0, all addresses 0);
  - EX/MEM and MEM/WB advance normally;
  - a stall lasts exactly 1 cycle for a single load.
- Flush_o = Branch_i & BranchEq_i & ~Stall_o.
- A branch in ID during a stall is re-evaluated in the next cycle once operands are valid.
- Branch bundles enter ID/EX unchanged; they write nothing and access no memory.
- Forwarding compares ID/EX rs1 and rs2 (separately for A and B):
  - 2'b10 if EX/MEM RegWrite=1, EX/MEM rd != 0 and EX/MEM rd matches;
  - else 2'b01 if MEM/WB RegWrite=1, MEM/WB rd != 0 and MEM/WB rd matches;
  - else 2'b00.
  - EX/MEM has priority when both stages match.
- x0 is never a stall or forwarding source.
- Stage registers are purely registered; Stall_o, PCWrite_o, Flush_o, ForwardA_o and ForwardB_o are combinational from registered state and current inputs.

Decomposition:
- Shared package (the header already holding the opcode/ALUOp constants) gains:
  - FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the bubble (all-zero) control value.
- Natural sub-module: ctrl_hazard_unit, holding the combinational stall, flush and forwarding logic.
- ctrl_pipeline keeps the three stage registers.

Test Plan:
- Reset: hold rst_i 2 cycles with RegWrite_i=1 -> all outputs 0, PCWrite_o=1; first post-reset bundle reaches RegWrite_WB_o at cycle 3.
- Pipeline latency: R-type (ALUOp_i=2'b10, RegWrite_i=1, rd=5) -> ALUOp_EX_o=2'b10 at +1, RDaddr_MEM_o=5 at +2, RegWrite_WB_o=1 and RDaddr_WB_o=5 at +3.
- Load-use: load rd=3, then ID rs1=3 -> Stall_o=1 and PCWrite_o=0 for exactly 1 cycle; bubble in EX (ALUOp_EX_o=0, MemRead/MemWrite at MEM 0 one cycle later); then ForwardA_o=2'b01.
- Forward priority: add rd=4, add rd=4, then add rs1=4, rs2=4 -> ForwardA_o=ForwardB_o=2'b10; with one unrelated instruction between -> 2'b01; with rd=0 -> 2'b00.
- Branch: Branch_i=1, BranchEq_i=1 -> Flush_o=1; same while a load-use stall is active -> Flush_o=0; BranchEq_i=0 -> Flush_o=0.
- Mid-run reset: assert rst_i while a store is in EX/MEM -> MemWrite_MEM_o=0 the next cycle and no RegWrite_WB_o pulse afterward.

Source files
------------

// File: rtl/ctrl_pipeline_pkg.sv
// Shared decode/pipeline constants, per-stage control bundles and the bubble value.
package ctrl_pipeline_pkg;

  localparam logic [1:0] ALUOP_LDST   = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
  localparam logic [1:0] ALUOP_ITYPE  = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Each stage bundle nests the one consumed by the next stage, so advancing is a field select.
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    wb_ctrl_t wb;
    logic     mem_read;
    logic     mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic      alu_src;
    mem_ctrl_t m;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '0;

  function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/ctrl_hazard_unit.sv
// Load-use stall, ID-stage branch flush and EX operand forwarding select.
// Purely combinational; no state.
module ctrl_hazard_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_ex_rs1,
  input  logic [REG_ADDR_W-1:0] i_ex_rs2,
  input  logic                  i_mem_reg_write,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_wb_reg_write,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_branch,
  input  logic                  i_branch_eq,
  output logic                  o_stall,
  output logic                  o_flush,
  output logic [1:0]            o_fwd_a,
  output logic [1:0]            o_fwd_b
);
  import ctrl_pipeline_pkg::*;

  logic w_load_use;
  logic w_mem_src;
  logic w_wb_src;

  // rs2 is compared even for opcodes that ignore it: a spurious stall costs one cycle, a missed one corrupts data.
  assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

  assign o_stall = w_load_use;
  assign o_flush = i_branch & i_branch_eq & ~w_load_use;

  assign w_mem_src = i_mem_reg_write && (i_mem_rd != '0);
  assign w_wb_src  = i_wb_reg_write  && (i_wb_rd  != '0);

  assign o_fwd_a = fwd_sel(w_mem_src && (i_mem_rd == i_ex_rs1), w_wb_src && (i_wb_rd == i_ex_rs1));
  assign o_fwd_b = fwd_sel(w_mem_src && (i_mem_rd == i_ex_rs2), w_wb_src && (i_wb_rd == i_ex_rs2));

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries the decode control bundle through ID/EX, EX/MEM and MEM/WB; EX outputs +1, MEM +2, WB +3 cycles.
// No backpressure beyond the load-use stall, which inserts one bubble into ID/EX while IF/ID and PC hold.
module ctrl_pipeline #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  Branch_i,
  input  logic                  MemRead_i,
  input  logic                  MemtoReg_i,
  input  logic [ALUOP_W-1:0]    ALUOp_i,
  input  logic                  MemWrite_i,
  input  logic                  ALUSrc_i,
  input  logic                  RegWrite_i,
  input  logic [REG_ADDR_W-1:0] RS1addr_i,
  input  logic [REG_ADDR_W-1:0] RS2addr_i,
  input  logic [REG_ADDR_W-1:0] RDaddr_i,
  input  logic                  BranchEq_i,
  output logic [ALUOP_W-1:0]    ALUOp_EX_o,
  output logic                  ALUSrc_EX_o,
  output logic [1:0]            ForwardA_o,
  output logic [1:0]            ForwardB_o,
  output logic                  MemRead_MEM_o,
  output logic                  MemWrite_MEM_o,
  output logic [REG_ADDR_W-1:0] RDaddr_MEM_o,
  output logic                  RegWrite_WB_o,
  output logic                  MemtoReg_WB_o,
  output logic [REG_ADDR_W-1:0] RDaddr_WB_o,
  output logic                  Stall_o,
  output logic                  PCWrite_o,
  output logic                  Flush_o
);
  import ctrl_pipeline_pkg::*;

  ex_ctrl_t              w_id_ctrl;
  logic                  w_stall;

  ex_ctrl_t              r_idex_ctrl;
  logic [ALUOP_W-1:0]    r_idex_aluop;
  logic [REG_ADDR_W-1:0] r_idex_rs1;
  logic [REG_ADDR_W-1:0] r_idex_rs2;
  logic [REG_ADDR_W-1:0] r_idex_rd;
  mem_ctrl_t             r_exmem_ctrl;
  logic [REG_ADDR_W-1:0] r_exmem_rd;
  wb_ctrl_t              r_memwb_ctrl;
  logic [REG_ADDR_W-1:0] r_memwb_rd;

  always_comb begin
    w_id_ctrl              = EX_CTRL_BUBBLE;
    w_id_ctrl.alu_src      = ALUSrc_i;
    w_id_ctrl.m.mem_read   = MemRead_i;
    w_id_ctrl.m.mem_write  = MemWrite_i;
    w_id_ctrl.m.wb.reg_write  = RegWrite_i;
    w_id_ctrl.m.wb.mem_to_reg = MemtoReg_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idex_ctrl  <= EX_CTRL_BUBBLE;
      r_idex_aluop <= '0;
      r_idex_rs1   <= '0;
      r_idex_rs2   <= '0;
      r_idex_rd    <= '0;
      r_exmem_ctrl <= '0;
      r_exmem_rd   <= '0;
      r_memwb_ctrl <= '0;
      r_memwb_rd   <= '0;
    end else begin
      if (w_stall) begin
        r_idex_ctrl  <= EX_CTRL_BUBBLE;
        r_idex_aluop <= '0;
        r_idex_rs1   <= '0;
        r_idex_rs2   <= '0;
        r_idex_rd    <= '0;
      end else begin
        r_idex_ctrl  <= w_id_ctrl;
        r_idex_aluop <= ALUOp_i;
        r_idex_rs1   <= RS1addr_i;
        r_idex_rs2   <= RS2addr_i;
        r_idex_rd    <= RDaddr_i;
      end
      r_exmem_ctrl <= r_idex_ctrl.m;
      r_exmem_rd   <= r_idex_rd;
      r_memwb_ctrl <= r_exmem_ctrl.wb;
      r_memwb_rd   <= r_exmem_rd;
    end
  end

  ctrl_hazard_unit #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .i_ex_mem_read   (r_idex_ctrl.m.mem_read),
    .i_ex_rd         (r_idex_rd),
    .i_ex_rs1        (r_idex_rs1),
    .i_ex_rs2        (r_idex_rs2),
    .i_mem_reg_write (r_exmem_ctrl.wb.reg_write),
    .i_mem_rd        (r_exmem_rd),
    .i_wb_reg_write  (r_memwb_ctrl.reg_write),
    .i_wb_rd         (r_memwb_rd),
    .i_id_rs1        (RS1addr_i),
    .i_id_rs2        (RS2addr_i),
    .i_branch        (Branch_i),
    .i_branch_eq     (BranchEq_i),
    .o_stall         (w_stall),
    .o_flush         (Flush_o),
    .o_fwd_a         (ForwardA_o),
    .o_fwd_b         (ForwardB_o)
  );

  assign ALUOp_EX_o     = r_idex_aluop;
  assign ALUSrc_EX_o    = r_idex_ctrl.alu_src;
  assign MemRead_MEM_o  = r_exmem_ctrl.mem_read;
  assign MemWrite_MEM_o = r_exmem_ctrl.mem_write;
  assign RDaddr_MEM_o   = r_exmem_rd;
  assign RegWrite_WB_o  = r_memwb_ctrl.reg_write;
  assign MemtoReg_WB_o  = r_memwb_ctrl.mem_to_reg;
  assign RDaddr_WB_o    = r_memwb_rd;
  assign Stall_o        = w_stall;
  assign PCWrite_o      = ~w_stall;

endmodule
